aes_decrypt_core: RTL and testbench



---
 rtl/aes_pkg.sv | 116 +++++++++++
 rtl/aes_decrypt_core_if.sv | 28 ++
 rtl/aes_inv_round.sv | 32 +++
 rtl/aes_decrypt_core.sv | 119 +++++++++++
 tb/tb_aes_decrypt_core.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, GF(2^8) helpers, S-boxes and the forward/inverse
// key-schedule steps used by both the encrypt and decrypt datapaths.
package aes_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [2:0] {
    S_NOKEY,
    S_KEXP,
    S_IDLE,
    S_RUN,
    S_OUT
  } aes_state_e;

  localparam int AES128_ROUNDS = 10;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse computed as x^254, which maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    return gmul(x252, x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = gf_inv(x);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic block_t fwd_key_step(input block_t rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {rc, 24'h0};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undoes fwd_key_step: recovers round key i-1 from round key i using rcon[i].
  function automatic block_t inv_key_step(input block_t rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0] ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes_decrypt_core_if.sv
// Key, ciphertext and plaintext channels of the AES-128 decrypt core, plus FSM state for debug.
interface aes_decrypt_core_if;

  // Handshake: a transfer happens on a rising clk edge where valid and ready are
  // both high; valid never waits on ready, and out_valid/pt_out hold until taken.
  logic               key_load;
  aes_pkg::block_t    key_in;
  logic               key_ready;
  logic               in_valid;
  logic               in_ready;
  aes_pkg::block_t    ct_in;
  logic               out_valid;
  logic               out_ready;
  aes_pkg::block_t    pt_out;
  logic               busy;
  aes_pkg::aes_state_e state;

  modport master (
    output key_load, key_in, in_valid, ct_in, out_ready,
    input  key_ready, in_ready, out_valid, pt_out, busy, state
  );

  modport slave (
    input  key_load, key_in, in_valid, ct_in, out_ready,
    output key_ready, in_ready, out_valid, pt_out, busy, state
  );

endinterface

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  block_t st_in,
  input  block_t rk,
  input  logic   is_final,
  output block_t st_out
);

  block_t sb;
  block_t ark;
  block_t mixed;

  // Byte n of a block is bits 127-8n; state row r, column c holds byte 4c+r.
  always_comb begin
    sb    = '0;
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sb[127-8*(4*c+r) -: 8] = inv_sbox(st_in[127-8*(4*((c+4-r)%4)+r) -: 8]);
      end
    end
    ark = sb ^ rk;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = inv_mix_column(ark[127-32*c -: 32]);
    end
    st_out = is_final ? ark : mixed;
  end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryptor: expands the key forward once to round key 10,
// then runs one inverse round per clock, rebuilding round keys in reverse.
module aes_decrypt_core
  import aes_pkg::*;
#(
  parameter int NR = AES128_ROUNDS  // only 10 is supported
) (
  input logic               clk,
  input logic               rst,
  aes_decrypt_core_if.slave bus
);

  localparam logic [3:0] RND_LAST = 4'(NR);

  aes_state_e state, state_next;
  block_t     rk, k10, st;
  block_t     rk_fwd, rk_prev, round_out;
  logic [3:0] rnd;
  logic       last_round;

  assign rk_fwd     = fwd_key_step(rk, rcon(rnd));
  assign rk_prev    = inv_key_step(rk, rcon(rnd));
  assign last_round = (rnd == 4'd1);

  aes_inv_round u_inv_round (
    .st_in   (st),
    .rk      (rk_prev),
    .is_final(last_round),
    .st_out  (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_NOKEY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_NOKEY: if (bus.key_load) state_next = S_KEXP;
      S_KEXP:  if (rnd == RND_LAST) state_next = S_IDLE;
      S_IDLE: begin
        if (bus.key_load)      state_next = S_KEXP;
        else if (bus.in_valid) state_next = S_RUN;
      end
      S_RUN:   if (last_round) state_next = S_OUT;
      S_OUT:   if (bus.out_ready) state_next = S_IDLE;
      default: state_next = S_NOKEY;
    endcase
  end

  // k10 survives across blocks; rk is reloaded from it at every accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      rk  <= '0;
      k10 <= '0;
      st  <= '0;
      rnd <= '0;
    end else begin
      case (state)
        S_NOKEY: begin
          if (bus.key_load) begin
            rk  <= bus.key_in;
            rnd <= 4'd1;
          end
        end
        S_KEXP: begin
          rk  <= rk_fwd;
          rnd <= rnd + 4'd1;
          if (rnd == RND_LAST) k10 <= rk_fwd;
        end
        S_IDLE: begin
          if (bus.key_load) begin
            rk  <= bus.key_in;
            rnd <= 4'd1;
          end else if (bus.in_valid) begin
            st  <= bus.ct_in ^ k10;
            rk  <= k10;
            rnd <= RND_LAST;
          end
        end
        S_RUN: begin
          st  <= round_out;
          rk  <= rk_prev;
          rnd <= rnd - 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.key_ready = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.pt_out    = '0;
    case (state)
      S_KEXP: bus.busy = 1'b1;
      S_IDLE: begin
        bus.key_ready = 1'b1;
        bus.in_ready  = !bus.key_load;
      end
      S_RUN: begin
        bus.key_ready = 1'b1;
        bus.busy      = 1'b1;
      end
      S_OUT: begin
        bus.key_ready = 1'b1;
        bus.out_valid = 1'b1;
        bus.pt_out    = st;
      end
      default: ;
    endcase
  end

  assign bus.state = state;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Bench for aes_decrypt_core: FIPS-197 known answers, backpressure, rekey,
// reset mid-run and random key/plaintext pairs from an independent encryptor.
module tb_aes_decrypt_core;
  import aes_pkg::*;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];
  logic [7:0] tb_sbox [256];

  aes_decrypt_core_if bus();

  aes_decrypt_core dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- independent encryption model ----------------
  function automatic logic [7:0] tb_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] p, a, b;
    p = 8'h00;
    a = a_in;
    b = b_in;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      tb_sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                   {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic tb_encrypt(input logic [127:0] key, input logic [127:0] pt,
                            output logic [127:0] ct);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  a0, a1, a2, a3;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {tb_sbox[tmp[31:24]], tb_sbox[tmp[23:16]], tb_sbox[tmp[15:8]], tb_sbox[tmp[7:0]]}
              ^ {rc, 24'h0};
        rc = tb_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++) t[b] = tb_sbox[s[b]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*((c+rr)%4)+rr];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = tb_mul(a0, 8'h02) ^ tb_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ tb_mul(a1, 8'h02) ^ tb_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ tb_mul(a2, 8'h02) ^ tb_mul(a3, 8'h03);
          s[4*c+3] = tb_mul(a0, 8'h03) ^ a1 ^ a2 ^ tb_mul(a3, 8'h02);
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) ct[127-8*b -: 8] = s[b];
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_key(input logic [127:0] key, output int lat);
    bus.key_load = 1'b1;
    bus.key_in   = key;
    tick();
    bus.key_load = 1'b0;
    lat = 0;
    while (!bus.key_ready && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic send_block(input logic [127:0] ct, output int lat);
    int guard;
    guard = 0;
    bus.ct_in    = ct;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 100) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      $display("FAIL accept_timeout got in_ready=0 for %0d cycles exp in_ready=1", guard);
      errors++;
    end
    tick();
    bus.in_valid = 1'b0;
    bus.ct_in    = ~ct;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic recv();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst          = 1'b1;
    bus.key_load = 1'b0;
    bus.key_in   = '0;
    bus.in_valid = 1'b1;
    bus.ct_in    = C1_CT;
    bus.out_ready = 1'b0;
    tick();
    tick();
    checks++; if (bus.state !== S_NOKEY) begin $display("FAIL reset_state got %0d exp %0d", bus.state, S_NOKEY); errors++; end
    checks++; if (bus.key_ready !== 1'b0) begin $display("FAIL reset_key_ready got %b exp 0", bus.key_ready); errors++; end
    checks++; if (bus.in_ready !== 1'b0) begin $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); errors++; end
    checks++; if (bus.out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); errors++; end
    checks++; if (bus.busy !== 1'b0) begin $display("FAIL reset_busy got %b exp 0", bus.busy); errors++; end
    checks++; if (bus.pt_out !== '0) begin $display("FAIL reset_pt_out got %h exp 0", bus.pt_out); errors++; end
    rst = 1'b0;
    tick();
    checks++; if (bus.in_ready !== 1'b0 || bus.state !== S_NOKEY) begin
      $display("FAIL nokey_ignores_in_valid got in_ready=%b state=%0d exp 0/%0d", bus.in_ready, bus.state, S_NOKEY); errors++; end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_kat_c1();
    int lat;
    load_key(C1_KEY, lat);
    checks++; if (lat !== 10) begin $display("FAIL c1_key_latency got %0d exp 10", lat); errors++; end
    checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      $display("FAIL c1_idle_flags got busy=%b in_ready=%b exp 0/1", bus.busy, bus.in_ready); errors++; end
    send_block(C1_CT, lat);
    checks++; if (lat !== 10) begin $display("FAIL c1_block_latency got %0d exp 10", lat); errors++; end
    checks++; if (bus.pt_out !== C1_PT) begin $display("FAIL c1_pt got %h exp %h", bus.pt_out, C1_PT); errors++; end
    recv();
    checks++; if (bus.out_valid !== 1'b0 || bus.state !== S_IDLE) begin
      $display("FAIL c1_after_handshake got out_valid=%b state=%0d exp 0/%0d", bus.out_valid, bus.state, S_IDLE); errors++; end
  endtask

  task automatic test_key_expansion();
    int lat;
    load_key(B_KEY, lat);
    checks++; if (lat !== 10) begin $display("FAIL b_key_latency got %0d exp 10", lat); errors++; end
    checks++; if (dut.k10 !== B_K10) begin $display("FAIL b_k10 got %h exp %h", dut.k10, B_K10); errors++; end
    send_block(B_CT, lat);
    checks++; if (lat !== 10) begin $display("FAIL b_block_latency got %0d exp 10", lat); errors++; end
    checks++; if (bus.pt_out !== B_PT) begin $display("FAIL b_pt got %h exp %h", bus.pt_out, B_PT); errors++; end
    recv();
  endtask

  task automatic test_backpressure();
    int lat;
    load_key(C1_KEY, lat);
    checks++; if (lat !== 10) begin $display("FAIL bp_key_latency got %0d exp 10", lat); errors++; end
    send_block(C1_CT, lat);
    bus.in_valid = 1'b1;
    bus.ct_in    = C1_CT;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.pt_out !== C1_PT || bus.in_ready !== 1'b0) begin
        $display("FAIL bp_hold cycle %0d got out_valid=%b in_ready=%b pt=%h exp 1/0/%h",
                 i, bus.out_valid, bus.in_ready, bus.pt_out, C1_PT); errors++; end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      $display("FAIL bp_release got out_valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready); errors++; end
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    checks++; if (lat !== 10 || bus.pt_out !== C1_PT) begin
      $display("FAIL bp_second_block got lat=%0d pt=%h exp 10/%h", lat, bus.pt_out, C1_PT); errors++; end
    recv();
  endtask

  task automatic test_rekey();
    int cnt;
    int lat;
    bus.key_load = 1'b1;
    bus.key_in   = B_KEY;
    bus.in_valid = 1'b1;
    bus.ct_in    = B_CT;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin $display("FAIL rekey_in_ready got %b exp 0", bus.in_ready); errors++; end
    tick();
    bus.key_load = 1'b0;
    checks++; if (bus.state !== S_KEXP || bus.key_ready !== 1'b0) begin
      $display("FAIL rekey_enter_kexp got state=%0d key_ready=%b exp %0d/0", bus.state, bus.key_ready, S_KEXP); errors++; end
    cnt = 0;
    while (!bus.key_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    checks++; if (cnt !== 10) begin $display("FAIL rekey_key_ready_low got %0d exp 10", cnt); errors++; end
    bus.in_valid = 1'b0;
    send_block(B_CT, lat);
    checks++; if (lat !== 10 || bus.pt_out !== B_PT) begin
      $display("FAIL rekey_pt got lat=%0d pt=%h exp 10/%h", lat, bus.pt_out, B_PT); errors++; end
    recv();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit bad;
    bus.ct_in    = B_CT;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    checks++; if (bus.state !== S_RUN) begin $display("FAIL midrun_state got %0d exp %0d", bus.state, S_RUN); errors++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.key_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
                  bus.in_ready !== 1'b0 || bus.pt_out !== '0) begin
      $display("FAIL midrun_outputs got key_ready=%b out_valid=%b busy=%b in_ready=%b pt=%h exp all 0",
               bus.key_ready, bus.out_valid, bus.busy, bus.in_ready, bus.pt_out); errors++; end
    checks++; if (dut.k10 !== '0) begin $display("FAIL midrun_k10_cleared got %h exp 0", dut.k10); errors++; end
    bus.in_valid = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      tick();
      if (bus.in_ready !== 1'b0 || bus.state !== S_NOKEY) bad = 1'b1;
    end
    checks++; if (bad) begin $display("FAIL midrun_in_valid_ignored got state=%0d exp %0d", bus.state, S_NOKEY); errors++; end
    bus.in_valid = 1'b0;
    load_key(B_KEY, lat);
    checks++; if (lat !== 10) begin $display("FAIL midrun_key_latency got %0d exp 10", lat); errors++; end
    send_block(B_CT, lat);
    checks++; if (bus.pt_out !== B_PT) begin $display("FAIL midrun_pt got %h exp %h", bus.pt_out, B_PT); errors++; end
    recv();
  endtask

  task automatic test_random();
    logic [127:0] key, pt, ct, exp_pt;
    int lat;
    for (int n = 0; n < 1000; n++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      tb_encrypt(key, pt, ct);
      exp_q.push_back(pt);
      repeat ($urandom_range(0, 2)) tick();
      load_key(key, lat);
      checks++; if (lat !== 10) begin $display("FAIL rand_key_latency iter %0d got %0d exp 10", n, lat); errors++; end
      repeat ($urandom_range(0, 3)) tick();
      send_block(ct, lat);
      repeat ($urandom_range(0, 3)) tick();
      exp_pt = exp_q.pop_front();
      checks++; if (bus.out_valid !== 1'b1 || bus.pt_out !== exp_pt) begin
        $display("FAIL rand_pt iter %0d got valid=%b pt=%h exp 1/%h", n, bus.out_valid, bus.pt_out, exp_pt); errors++; end
      recv();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.key_load  = 1'b0;
    bus.key_in    = '0;
    bus.in_valid  = 1'b0;
    bus.ct_in     = '0;
    bus.out_ready = 1'b0;
    build_sbox();
    test_reset();
    test_kat_c1();
    test_key_expansion();
    test_backpressure();
    test_rekey();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
